// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline sequencer for the 5-stage RV32I core.
// Chooses one action per cycle and drives the matching hold, flush and bubble
// controls for the PC updater and the pipeline registers. Action priority is
// INIT > FREEZE > FLUSH > STALL > RUN. It also produces the EX-stage operand
// forwarding selects.
// Optional feature: define HAZARD_PERF_CNT_EN to add saturating
// stall/flush/freeze cycle counters and their output ports.
module hazard_sequencer #(
    parameter logic [31:0] NOP_INST    = 32'h00000013,
    parameter int          INIT_CYCLES = 2,
    parameter int          CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           rs1_id,
    input  logic [4:0]           rs2_id,
    input  logic                 use_rs1_id,
    input  logic                 use_rs2_id,
    input  logic [4:0]           rs1_ex,
    input  logic [4:0]           rs2_ex,
    input  logic [4:0]           rd_ex,
    input  logic                 regwr_ex,
    input  logic                 memrd_ex,
    input  logic [4:0]           rd_mem,
    input  logic                 regwr_mem,
    input  logic [4:0]           rd_wb,
    input  logic                 regwr_wb,
    input  logic                 branch_taken_ex,
    input  logic                 mem_busy,
    output logic                 hold_pc,
    output logic                 hold_ifid,
    output logic                 hold_idex,
    output logic                 hold_exmem,
    output logic                 flush_ifid,
    output logic                 flush_idex,
    output logic                 bubble_idex,
    output logic                 bubble_memwb,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt,
    output logic [CNT_WIDTH-1:0] freeze_cnt,
`endif
    output logic [2:0]           last_action
);

    typedef enum logic [2:0] {
        ACT_RUN    = 3'd0,
        ACT_INIT   = 3'd1,
        ACT_STALL  = 3'd2,
        ACT_FLUSH  = 3'd3,
        ACT_FREEZE = 3'd4
    } action_t;

    // The flush word is consumed by the pipeline registers. It must be a
    // full-width (uncompressed) instruction, and at least one fill cycle is
    // needed.
    if (INIT_CYCLES < 1) begin : g_bad_init_cycles
        $error("hazard_sequencer: INIT_CYCLES must be at least 1");
    end
    if (NOP_INST[1:0] != 2'b11) begin : g_bad_nop_inst
        $error("hazard_sequencer: NOP_INST must be a 32-bit instruction encoding");
    end

    localparam int ICW = $clog2(INIT_CYCLES + 1);
    localparam logic [ICW-1:0] INIT_DONE = ICW'(INIT_CYCLES);

    logic [ICW-1:0] init_cnt;
    logic           init_active;
    logic           br_pend;
    logic           load_use;
    action_t        action;

    assign init_active = rst | (init_cnt != INIT_DONE);

    assign load_use = memrd_ex & regwr_ex & (rd_ex != 5'd0) &
                      ((use_rs1_id & (rs1_id == rd_ex)) |
                       (use_rs2_id & (rs2_id == rd_ex)));

    // Fill counter: restarts on reset and counts the post-release flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt <= '0;
        end else if (init_cnt != INIT_DONE) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    // Remembers a redirect that arrived while frozen. The branch still sits in
    // EX, so it gets its flush on the first cycle after the freeze ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_pend <= 1'b0;
        end else if (action == ACT_FREEZE) begin
            br_pend <= br_pend | branch_taken_ex;
        end else begin
            br_pend <= 1'b0;
        end
    end

    // Action select. This is a strict priority chain, so exactly one action
    // is active each cycle.
    always_comb begin
        action = ACT_RUN;
        if (init_active) begin
            action = ACT_INIT;
        end else if (mem_busy) begin
            action = ACT_FREEZE;
        end else if (branch_taken_ex | br_pend) begin
            action = ACT_FLUSH;
        end else if (load_use) begin
            action = ACT_STALL;
        end
    end

    // Decode the action into register controls. Outputs not assigned in a
    // branch keep their default of 0.
    always_comb begin
        hold_pc      = 1'b0;
        hold_ifid    = 1'b0;
        hold_idex    = 1'b0;
        hold_exmem   = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        bubble_idex  = 1'b0;
        bubble_memwb = 1'b0;
        case (action)
            ACT_INIT: begin
                hold_pc    = 1'b1;
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end
            ACT_FREEZE: begin
                hold_pc      = 1'b1;
                hold_ifid    = 1'b1;
                hold_idex    = 1'b1;
                hold_exmem   = 1'b1;
                bubble_memwb = 1'b1;
            end
            ACT_FLUSH: begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end
            ACT_STALL: begin
                hold_pc     = 1'b1;
                hold_ifid   = 1'b1;
                bubble_idex = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand forwarding. The MEM stage holds the younger result, so it wins
    // over WB. x0 is never forwarded. Forwarding stays live during FREEZE but
    // is forced to the regfile while the pipeline fills.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!init_active) begin
            if (regwr_mem && rd_mem != 5'd0 && rd_mem == rs1_ex) begin
                fwd_a = 2'b01;
            end else if (regwr_wb && rd_wb != 5'd0 && rd_wb == rs1_ex) begin
                fwd_a = 2'b10;
            end
            if (regwr_mem && rd_mem != 5'd0 && rd_mem == rs2_ex) begin
                fwd_b = 2'b01;
            end else if (regwr_wb && rd_wb != 5'd0 && rd_wb == rs2_ex) begin
                fwd_b = 2'b10;
            end
        end
    end

    // Record the action taken this cycle, for observation next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_action <= ACT_INIT;
        end else begin
            last_action <= action;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating per-action cycle counters. INIT cycles are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (action == ACT_STALL && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (action == ACT_FLUSH && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if (action == ACT_FREEZE && freeze_cnt != '1) begin
                freeze_cnt <= freeze_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline sequencer for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Decides each cycle whether to advance, stall, flush or freeze the pipeline registers and the PC updater.
- Generates the EX-stage operand forwarding selects.
- Runs a post-reset fill sequence so the pipeline registers hold bubbles before the first fetch.

Parameters:
- NOP_INST, 32'h00000013, bubble/flush word that pipeline registers load when flushed or bubbled.
- INIT_CYCLES, 2, flush cycles after reset release, min 1.
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clk in 1: clock, rising edge.
- rst in 1: synchronous, active-high reset.
- rs1_id, rs2_id in 5: ID-stage source registers.
- use_rs1_id, use_rs2_id in 1: ID instruction reads rs1 / rs2.
- rs1_ex, rs2_ex in 5: EX-stage source registers.
- rd_ex in 5, regwr_ex in 1, memrd_ex in 1: EX destination, writes register, is a load.
- rd_mem in 5, regwr_mem in 1: MEM destination and write enable.
- rd_wb in 5, regwr_wb in 1: WB destination and write enable.
- branch_taken_ex in 1: PC updater redirects this cycle.
- mem_busy in 1: data memory not ready.
- hold_pc, hold_ifid, hold_idex, hold_exmem out 1: register keeps its value.
- flush_ifid, flush_idex out 1: register loads NOP_INST.
- bubble_idex, bubble_memwb out 1: register loads NOP_INST (stall bubble).
- fwd_a, fwd_b out 2: operand source. 00 = regfile, 01 = EX/MEM result, 10 = WB result.
- last_action out 3: registered action of the previous cycle. 0 RUN, 1 INIT, 2 STALL, 3 FLUSH, 4 FREEZE.
- stall_cnt, flush_cnt, freeze_cnt out CNT_WIDTH: only when HAZARD_PERF_CNT_EN is defined.

Behaviour:
- Control outputs are combinational from the current state and inputs. last_action, the init counter and the perf counters are registered.
- Action priority, highest first: INIT > FREEZE > FLUSH > STALL > RUN. Exactly one action per cycle.
- INIT: entered by rst. While rst=1 and for the first INIT_CYCLES cycles after release:
  - hold_pc=1, flush_ifid=1, flush_idex=1, all other holds and bubbles 0, fwd 00.
  - Then RUN. mem_busy and branch_taken_ex are ignored during INIT.
- FREEZE (mem_busy=1): hold_pc, hold_ifid, hold_idex, hold_exmem=1; bubble_memwb=1; no flush.
  - A branch_taken_ex during FREEZE is not lost: the branch stays in EX and is flushed in the first cycle after mem_busy falls.
- FLUSH (branch_taken_ex=1): flush_ifid=1 and flush_idex=1 for exactly that cycle; PC advances to the target. An overlapping load-use condition is discarded.
- STALL (load-use): condition is memrd_ex & regwr_ex & rd_ex!=0 & ((use_rs1_id & rs1_id==rd_ex) | (use_rs2_id & rs2_id==rd_ex)).
  - Response: hold_pc=1, hold_ifid=1, bubble_idex=1 for one cycle.
  - The next cycle re-evaluates; the load is then in MEM and is resolved by forwarding.
- RUN: all holds, flushes and bubbles are 0.
- Forwarding (fwd_a from rs1_ex, fwd_b from rs2_ex; shown for fwd_a):
  - 01 if regwr_mem & rd_mem!=0 & rd_mem==rs1_ex.
  - Otherwise 10 if regwr_wb & rd_wb!=0 & rd_wb==rs1_ex.
  - Otherwise 00.
  - MEM has priority over WB. x0 is never forwarded.
  - Forwarding is also driven during FREEZE.
- Reset mid-operation: rst=1 at any time forces INIT, restarts the init counter at 0, sets last_action=1 and clears the counters.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt, flush_cnt and freeze_cnt each increment by 1 per cycle spent in STALL, FLUSH and FREEZE respectively.
  - They saturate at all-ones and clear on rst.
  - INIT cycles are not counted.
- Undefined: the three ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 3 cycles, then release, INIT_CYCLES=2.
  - During rst and release cycles 1-2: hold_pc=1, flush_ifid=flush_idex=1.
  - Release cycle 3: all controls 0. last_action reads 1,1 then 0.
- Load-use: memrd_ex=1, regwr_ex=1, rd_ex=5, use_rs2_id=1, rs2_id=5.
  - That cycle: hold_pc=hold_ifid=bubble_idex=1, no flush.
  - Next cycle with rd_mem=5, regwr_mem=1, rs2_ex=5: fwd_b=01. stall_cnt=1.
- Branch + load-use in the same cycle: branch_taken_ex=1 with a load-use hit.
  - flush_ifid=flush_idex=1, bubble_idex=0, hold_pc=0. flush_cnt=1, stall_cnt unchanged.
- Freeze with pending branch: mem_busy=1 for 3 cycles with branch_taken_ex=1.
  - 3 cycles of all holds=1 and bubble_memwb=1, no flush.
  - Cycle 4 (mem_busy=0): flush pulse. freeze_cnt=3, flush_cnt=1.
- Forwarding priority: rs1_ex=7, rd_mem=7/regwr_mem=1, rd_wb=7/regwr_wb=1 -> fwd_a=01.
  - Then regwr_mem=0 -> fwd_a=10.
  - Then rs1_ex=rd_mem=rd_wb=0 with both write enables 1 -> fwd_a=00.
- Mid-run reset: rst=1 during a FREEZE.
  - Next cycle: last_action=1, counters 0, init flush sequence restarts with hold_pc=1.
